// File: rtl/boot_pkg.sv
// Shared types and frame constants for the instruction-memory boot loader.
package boot_pkg;

  localparam int LEN_W  = 16;
  localparam int LANE_W = 2;

  typedef enum logic [2:0] {
    LEN_LO,
    LEN_HI,
    DATA,
    CHECK,
    DONE,
    ERROR
  } boot_state_e;

  // Largest image, in 32-bit words, that fits in an instruction memory of imem_size bytes.
  function automatic int max_words(input int imem_size);
    return imem_size / 4;
  endfunction

endpackage

// File: rtl/boot_word_assembler.sv
// Packs accepted stream bytes little-endian into 32-bit words; word_valid_o pulses
// for one cycle, the cycle after the fourth byte is accepted.
module boot_word_assembler
  import boot_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        accept_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  logic [LANE_W-1:0] lane_q, lane_d;
  logic [23:0]       shift_q, shift_d;
  logic [31:0]       word_q, word_d;
  logic              valid_q, valid_d;

  always_comb begin
    lane_d  = lane_q;
    shift_d = shift_q;
    word_d  = word_q;
    valid_d = 1'b0;
    if (clear_i) begin
      lane_d = '0;
    end else if (accept_i) begin
      if (&lane_q) begin
        // Earlier lanes have shifted down, so the newest byte lands on bits 31:24.
        word_d  = {byte_i, shift_q};
        valid_d = 1'b1;
        lane_d  = '0;
      end else begin
        shift_d = {byte_i, shift_q[23:8]};
        lane_d  = lane_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      lane_q  <= '0;
      shift_q <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      lane_q  <= lane_d;
      shift_q <= shift_d;
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

  assign word_o       = word_q;
  assign word_valid_o = valid_q;

endmodule

// File: rtl/imem_boot_loader.sv
// Framed byte-stream loader: writes the image into instruction memory and holds the CPU in reset.
// Defining BOOT_CHECKSUM_EN requires a trailing XOR checksum byte after the payload.
module imem_boot_loader
  import boot_pkg::*;
#(
  parameter int          IMEM_SIZE = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             restart_i,
  input  logic             byte_valid_i,
  input  logic [7:0]       byte_data_i,
  output logic             byte_ready_o,
  output logic             imem_we_o,
  output logic [31:0]      imem_addr_o,
  output logic [31:0]      imem_wdata_o,
  output logic             cpu_reset_o,
  output logic             done_o,
  output logic             error_o,
  output logic [LEN_W-1:0] words_loaded_o
);

  localparam logic [31:0] MAX_N = 32'(max_words(IMEM_SIZE));

  boot_state_e      state_q, state_d;
  logic [7:0]       len_lo_q, len_lo_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] words_q, words_d;
  logic             ready_q, ready_d;
  logic             cpu_reset_q, cpu_reset_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]       csum_q, csum_d;
`endif

  logic             handshake;
  logic             final_write;
  logic             data_accept;
  logic             asm_clear;
  logic [LEN_W-1:0] len_n;
  logic [31:0]      asm_word;
  logic             asm_valid;

  assign handshake   = byte_valid_i && ready_q;
  assign len_n       = {byte_data_i, len_lo_q};
  // The write strobe of the last word; any byte arriving alongside it is not payload.
  assign final_write = asm_valid && (words_q + 1'b1 == len_q);
  assign data_accept = handshake && (state_q == DATA) && !final_write && !restart_i;
  assign asm_clear   = restart_i || (state_q != DATA);

  boot_word_assembler u_asm (
    .clock        (clock),
    .reset        (reset),
    .clear_i      (asm_clear),
    .accept_i     (data_accept),
    .byte_i       (byte_data_i),
    .word_o       (asm_word),
    .word_valid_o (asm_valid)
  );

  always_comb begin
    state_d  = state_q;
    len_lo_d = len_lo_q;
    len_d    = len_q;
    words_d  = words_q;
    if (asm_valid) begin
      words_d = words_q + 1'b1;
    end

    case (state_q)
      LEN_LO: begin
        if (handshake) begin
          len_lo_d = byte_data_i;
          state_d  = LEN_HI;
        end
      end
      LEN_HI: begin
        if (handshake) begin
          len_d = len_n;
          if ({16'd0, len_n} > MAX_N) begin
            state_d = ERROR;
          end else if (len_n == '0) begin
`ifdef BOOT_CHECKSUM_EN
            state_d = CHECK;
`else
            state_d = DONE;
`endif
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (final_write) begin
`ifdef BOOT_CHECKSUM_EN
          // At full byte rate the checksum byte shares the cycle with the last write.
          if (handshake) begin
            state_d = (byte_data_i == csum_q) ? DONE : ERROR;
          end else begin
            state_d = CHECK;
          end
`else
          state_d = DONE;
`endif
        end
      end
`ifdef BOOT_CHECKSUM_EN
      CHECK: begin
        if (handshake) begin
          state_d = (byte_data_i == csum_q) ? DONE : ERROR;
        end
      end
`endif
      default: begin
      end
    endcase

    if (restart_i) begin
      state_d = LEN_LO;
      words_d = '0;
    end

    ready_d     = state_d inside {LEN_LO, LEN_HI, DATA, CHECK};
    done_d      = (state_d == DONE);
    error_d     = (state_d == ERROR);
    // Release lags DONE entry by one cycle; any exit from DONE re-asserts it at once.
    cpu_reset_d = !((state_q == DONE) && (state_d == DONE));
  end

`ifdef BOOT_CHECKSUM_EN
  always_comb begin
    csum_d = csum_q;
    if (restart_i || (state_q == LEN_LO)) begin
      csum_d = '0;
    end else if (data_accept) begin
      csum_d = csum_q ^ byte_data_i;
    end
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= LEN_LO;
      len_lo_q    <= '0;
      len_q       <= '0;
      words_q     <= '0;
      ready_q     <= 1'b1;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      len_lo_q    <= len_lo_d;
      len_q       <= len_d;
      words_q     <= words_d;
      ready_q     <= ready_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
      error_q     <= error_d;
`ifdef BOOT_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign byte_ready_o   = ready_q;
  assign imem_we_o      = asm_valid;
  assign imem_wdata_o   = asm_word;
  assign imem_addr_o    = BASE_ADDR + 32'({words_q, 2'b00});
  assign cpu_reset_o    = cpu_reset_q;
  assign done_o         = done_q;
  assign error_o        = error_q;
  assign words_loaded_o = words_q;

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
Byte-stream boot loader sitting directly upstream of the RV32I multi-cycle CPU in riscv_soc.
- Accepts a framed program image over a valid/ready byte stream (UART RX or host bridge).
- Packs the bytes into little-endian 32-bit words and writes them into instruction memory.
- Holds the CPU in reset until the image loads cleanly, then releases it to fetch from BASE_ADDR.

Parameters:
- IMEM_SIZE, 4096: instruction memory size in bytes; maximum image is IMEM_SIZE/4 words.
- BASE_ADDR, 32'h0000_0000: byte address of the first word written; word-aligned.

Ports:
- clock, input, 1: system clock.
- reset, input, 1: synchronous, active-high.
- restart_i, input, 1: single-cycle pulse; aborts any load and waits for a new frame.
- byte_valid_i, input, 1: a byte is offered on byte_data_i.
- byte_data_i, input, 8: stream byte.
- byte_ready_o, output, 1: loader accepts a byte this cycle. Transfer occurs when valid && ready.
- imem_we_o, output, 1: one-cycle instruction-memory write strobe.
- imem_addr_o, output, 32: byte address of the write.
- imem_wdata_o, output, 32: write data.
- cpu_reset_o, output, 1: reset to the CPU core; high unless state is DONE.
- done_o, output, 1: image loaded and accepted.
- error_o, output, 1: frame rejected.
- words_loaded_o, output, 16: count of words written in the current frame.

Behaviour:
- Frame format: LEN_LO, LEN_HI (16-bit word count N, little-endian), 4*N payload bytes (byte0 = bits 7:0), then the optional checksum byte.
- States: LEN_LO -> LEN_HI -> DATA -> [CHECK] -> DONE; ERROR.
- Each state advances only on an accepted byte, except:
  - LEN_HI with N == 0 goes straight to CHECK, or to DONE without the checksum feature.
  - LEN_HI with N > IMEM_SIZE/4 goes to ERROR.
- Reset values:
  - State LEN_LO; byte_ready_o 1.
  - imem_we_o 0, imem_addr_o BASE_ADDR, imem_wdata_o 0.
  - cpu_reset_o 1, done_o 0, error_o 0.
  - words_loaded_o 0; byte lane counter 0.
- byte_ready_o is 1 in LEN_LO, LEN_HI, DATA and CHECK, and 0 in DONE and ERROR. It does not depend combinationally on byte_valid_i.
- DATA state:
  - A 2-bit lane counter selects the byte lane.
  - On acceptance of lane 3, the full word is registered. The next cycle has imem_we_o=1, imem_addr_o=BASE_ADDR+4*words_loaded_o, and imem_wdata_o=the word.
  - words_loaded_o increments in that same cycle.
  - Write latency is 1 cycle after the 4th byte handshake. Back-to-back bytes are sustainable at 1 byte/cycle.
- When words_loaded_o reaches N (counting the write being issued), go to CHECK, or to DONE without the feature.
- The address never wraps; the length check guarantees the last address is BASE_ADDR+IMEM_SIZE-4.
- DONE: cpu_reset_o drops to 0 one cycle after DONE is entered (registered). done_o=1. The state holds until reset or restart_i.
- ERROR: error_o=1, cpu_reset_o=1. The state holds until reset or restart_i. Memory contents are undefined (partial writes allowed).
- restart_i in any state:
  - Next state is LEN_LO.
  - A byte handshaked in the same cycle is discarded.
  - Counters clear; done_o and error_o clear; cpu_reset_o goes to 1 the next cycle.
  - A write already registered for that cycle still completes; no new write is issued.
- reset mid-load behaves like restart_i, and also clears outputs to their reset values.
- byte_valid_i gaps at any point stall progress only; data is not affected.

Optional Feature:
- Macro: BOOT_CHECKSUM_EN.
- Defined:
  - CHECK state exists. The loader keeps a running XOR of all payload bytes (length bytes excluded).
  - The accepted CHECK byte must equal the running XOR: match goes to DONE, mismatch goes to ERROR.
  - For N == 0 the expected checksum is 8'h00.
- Undefined:
  - No CHECK state. DONE is entered in the cycle after the last write strobe.
  - No trailing byte is consumed.

Decomposition:
- Package boot_pkg holds:
  - boot_state_e enum (LEN_LO, LEN_HI, DATA, CHECK, DONE, ERROR).
  - MAX_WORDS = IMEM_SIZE/4 as a function/localparam helper.
  - Frame field width constants: LEN_W=16, LANE_W=2.
- One sub-module: boot_word_assembler. It takes byte in + accept + lane clear, and outputs word + word_valid. It owns the lane counter and shift register.

Test Plan:
- Frame 02 00 93 00 A0 00 13 01 40 01 [60], fed at 1 byte/cycle. Required:
  - Writes 0x00A00093 @0x0 and 0x01400113 @0x4.
  - words_loaded_o=2, done_o=1, cpu_reset_o falls.
  - The CPU then executes, giving x1=10 and x2=20.
- Same frame with random 0-5 cycle byte_valid_i gaps -> identical writes and completion; no duplicate imem_we_o pulses.
- With BOOT_CHECKSUM_EN, checksum byte 0x61 instead of 0x60 -> error_o=1, cpu_reset_o stays 1, byte_ready_o=0.
- Length bytes 01 04 (N=1025 > 1024) -> ERROR immediately after LEN_HI; no imem_we_o pulse.
- restart_i asserted after 5 payload bytes, then the full valid frame is sent -> first write at 0x0 from the new frame; done_o=1; no stray write from the aborted frame.
- Frame 00 00 [00] -> done_o=1 with no writes and words_loaded_o=0; repeat with reset asserted mid-DATA -> all outputs return to reset values.
